// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//   Hazard detection and forwarding control for an in-order pipeline.
//   It tracks the instruction in EX (entry 0) and FWD_DEPTH post-EX stages,
//   chooses an EX operand bypass source for rs/rt, detects load-use hazards,
//   and prioritises data-memory freeze over branch flush over load-use stall.
//   Stall and flush events are counted in saturating counters.
//
// Ports
//   clk, rst_n               : clock, asynchronous active-low reset
//   id_valid                 : ID stage holds a real instruction
//   id_rs, id_rt             : ID source registers
//   id_use_rs, id_use_rt     : ID instruction reads rs / rt
//   id_dest                  : ID destination register (after RegDst)
//   id_regwrite, id_memread  : ID control bits
//   ex_branch_taken          : branch resolved taken in EX this cycle
//   dmem_stall               : data memory not ready, freeze the pipeline
//   stall_if_id              : hold PC and IF/ID
//   bubble_id_ex             : load zeroed controls into ID/EX
//   flush_if_id              : invalidate IF/ID
//   freeze_all               : hold every pipeline register
//   fwd_sel_a, fwd_sel_b     : EX operand source, 0 = ID/EX value, k = stage k
//   stall_cnt, flush_cnt     : saturating event counters
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter  int RA_W      = 5,
    parameter  int FWD_DEPTH = 2,
    parameter  int LOAD_FWD  = 2,
    parameter  int CNT_W     = 16,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    input  logic             dmem_stall,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             freeze_all,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [RA_W-1:0] dest;
        logic            regwrite;
        logic            is_load;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
    } entry_t;

    // Entry 0 is EX; entry k is the k-th stage after EX.
    logic [FWD_DEPTH:0] ent_valid;
    entry_t             ent [0:FWD_DEPTH];
    logic               load_use;

    // r0 is hard-wired zero, so a write to it never produces a hazard.
    function automatic logic writes_reg(input logic v, input entry_t e,
                                        input logic [RA_W-1:0] r);
        return v && e.regwrite && (e.dest == r) && (r != '0);
    endfunction

    // Load-use: a load that has not yet reached a forwardable stage by the
    // time the ID instruction would reach EX.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no latch is inferred.
        load_use = 1'b0;
        for (int k = 0; k <= FWD_DEPTH; k++) begin
            if ((k + 2 <= LOAD_FWD) && ent[k].is_load &&
                ((id_use_rs && writes_reg(ent_valid[k], ent[k], id_rs)) ||
                 (id_use_rt && writes_reg(ent_valid[k], ent[k], id_rt))))
                load_use = 1'b1;
        end
        load_use = load_use && id_valid;
    end

    // Forwarding: scan oldest to youngest so the youngest (smallest k) match
    // wins. Loads in stages whose data is not yet available are skipped.
    always_comb begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if ((k >= LOAD_FWD) || !ent[k].is_load) begin
                if (writes_reg(ent_valid[k], ent[k], ent[0].rs))
                    fwd_sel_a = SEL_W'(k);
                if (writes_reg(ent_valid[k], ent[k], ent[0].rt))
                    fwd_sel_b = SEL_W'(k);
            end
        end
        if (!ent_valid[0]) begin
            fwd_sel_a = '0;
            fwd_sel_b = '0;
        end
    end

    // Control outputs; reset overrides an in-progress freeze or stall at once.
    always_comb begin
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        freeze_all   = 1'b0;
        if (!rst_n) begin
            freeze_all = 1'b0;
        end else if (dmem_stall) begin
            freeze_all  = 1'b1;
            stall_if_id = 1'b1;
        end else if (ex_branch_taken) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (load_use) begin
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end
    end

    // Valid bits and counters carry architectural meaning and are reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!freeze_all) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            ent_valid <= {ent_valid[FWD_DEPTH-1:0], id_valid && !bubble_id_ex};
            if (flush_if_id && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (stall_if_id && bubble_id_ex && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // NOTE: the payload fields are qualified by the valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!freeze_all) begin
            ent[0] <= '{dest: id_dest, regwrite: id_regwrite, is_load: id_memread,
                        rs: id_rs, rt: id_rt};
            for (int k = 1; k <= FWD_DEPTH; k++)
                ent[k] <= ent[k-1];
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_ctrl
//   Directed bench for hazard_forward_ctrl. Two instances share stimulus:
//   one with default parameters and one with CNT_W=4 for counter saturation.
//   The driver pushes the hand-computed response of each cycle into a queue;
//   the monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_forward_ctrl;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] dest;
        logic       rw, mr, br, dm;
    } stim_t;

    typedef struct {
        string name;
        logic  stall, bubble, flush, freeze;
        int    sa, sb, sc, fc;
    } exp_t;

    logic       clk, rst_n;
    logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       ex_branch_taken, dmem_stall;

    logic        stall_if_id, bubble_id_ex, flush_if_id, freeze_all;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        stall_s, bubble_s, flush_s, freeze_s;
    logic [1:0]  sel_a_s, sel_b_s;
    logic [3:0]  stall_cnt_s, flush_cnt_s;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    hazard_forward_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .dmem_stall(dmem_stall),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .freeze_all(freeze_all),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_forward_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .dmem_stall(dmem_stall),
        .stall_if_id(stall_s), .bubble_id_ex(bubble_s),
        .flush_if_id(flush_s), .freeze_all(freeze_s),
        .fwd_sel_a(sel_a_s), .fwd_sel_b(sel_b_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic stim_t ins(input int rs, input int rt, input int dest,
                                  input bit mr, input bit br = 0, input bit dm = 0);
        stim_t s;
        s.v = 1'b1; s.rs = 5'(rs); s.rt = 5'(rt); s.urs = 1'b1; s.urt = 1'b1;
        s.dest = 5'(dest); s.rw = 1'b1; s.mr = mr; s.br = br; s.dm = dm;
        return s;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s.v = 1'b0; s.rs = '0; s.rt = '0; s.urs = 1'b0; s.urt = 1'b0;
        s.dest = '0; s.rw = 1'b0; s.mr = 1'b0; s.br = 1'b0; s.dm = 1'b0;
        return s;
    endfunction

    function automatic exp_t ex(input string n, input bit st, input bit bu, input bit fl,
                                input bit fr, input int sa, input int sb,
                                input int sc, input int fc);
        exp_t e;
        e.name = n; e.stall = st; e.bubble = bu; e.flush = fl; e.freeze = fr;
        e.sa = sa; e.sb = sb; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        id_valid = s.v; id_rs = s.rs; id_rt = s.rt;
        id_use_rs = s.urs; id_use_rt = s.urt; id_dest = s.dest;
        id_regwrite = s.rw; id_memread = s.mr;
        ex_branch_taken = s.br; dmem_stall = s.dm;
    endtask

    // One pipeline cycle: drive inputs just after the edge, queue the response.
    task automatic step(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        apply(s);
        q.push_back(e);
    endtask

    // Scoreboard monitor; the 4-bit counters of the second instance saturate.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] exp_ctrl;
            e = q.pop_front();
            exp_ctrl = {e.stall, e.bubble, e.flush, e.freeze, 2'(e.sa), 2'(e.sb)};
            check({e.name, ".ctrl"},
                  {stall_if_id, bubble_id_ex, flush_if_id, freeze_all, fwd_sel_a, fwd_sel_b},
                  exp_ctrl);
            check({e.name, ".ctrl_s"},
                  {stall_s, bubble_s, flush_s, freeze_s, sel_a_s, sel_b_s}, exp_ctrl);
            check({e.name, ".stall_cnt"}, stall_cnt, e.sc);
            check({e.name, ".flush_cnt"}, flush_cnt, e.fc);
            check({e.name, ".stall_cnt_s"}, stall_cnt_s, (e.sc > 15) ? 15 : e.sc);
            check({e.name, ".flush_cnt_s"}, flush_cnt_s, (e.fc > 15) ? 15 : e.fc);
        end
    end

    task automatic check_all_zero(input string n);
        check({n, ".ctrl"},
              {stall_if_id, bubble_id_ex, flush_if_id, freeze_all, fwd_sel_a, fwd_sel_b}, 0);
        check({n, ".ctrl_s"}, {stall_s, bubble_s, flush_s, freeze_s, sel_a_s, sel_b_s}, 0);
        check({n, ".cnt"}, {stall_cnt, flush_cnt}, 0);
        check({n, ".cnt_s"}, {stall_cnt_s, flush_cnt_s}, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        apply(nop());
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        #9 rst_n = 1'b1;

        // Forwarding from EX/MEM then MEM/WB.
        step(ins(1, 2, 3, 0),  ex("fwd_c1",     0, 0, 0, 0, 0, 0, 0, 0));
        step(ins(3, 1, 5, 0),  ex("fwd_c2",     0, 0, 0, 0, 0, 0, 0, 0));
        step(ins(1, 3, 7, 0),  ex("fwd_ex_mem", 0, 0, 0, 0, 1, 0, 0, 0));
        step(nop(),            ex("fwd_mem_wb", 0, 0, 0, 0, 0, 2, 0, 0));

        // Load-use stall, then forwarding from the load at stage 2.
        step(ins(1, 0, 4, 1),  ex("lw_issue",    0, 0, 0, 0, 0, 0, 0, 0));
        step(ins(4, 2, 8, 0),  ex("load_use",    1, 1, 0, 0, 0, 0, 0, 0));
        step(ins(4, 2, 8, 0),  ex("after_stall", 0, 0, 0, 0, 0, 0, 1, 0));
        step(nop(),            ex("load_fwd2",   0, 0, 0, 0, 2, 0, 1, 0));

        // r0 as destination never stalls or forwards.
        step(ins(1, 2, 0, 1),  ex("r0_c1",   0, 0, 0, 0, 0, 0, 1, 0));
        step(ins(0, 0, 9, 0),  ex("r0_load", 0, 0, 0, 0, 0, 0, 1, 0));
        step(ins(0, 0, 0, 0),  ex("r0_c3",   0, 0, 0, 0, 0, 0, 1, 0));
        step(nop(),            ex("r0_c4",   0, 0, 0, 0, 0, 0, 1, 0));

        // Branch wins over load-use.
        step(ins(1, 0, 4, 1),        ex("br_c1",    0, 0, 0, 0, 0, 0, 1, 0));
        step(ins(4, 4, 10, 0, 1),    ex("br_lu",    0, 1, 1, 0, 0, 0, 1, 0));
        step(nop(),                  ex("br_after", 0, 0, 0, 0, 0, 0, 1, 1));

        // Freeze for three cycles mid-forward (branch ignored while frozen).
        step(ins(2, 0, 11, 0),       ex("frz_c1", 0, 0, 0, 0, 0, 0, 1, 1));
        step(ins(11, 11, 12, 0),     ex("frz_c2", 0, 0, 0, 0, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++)
            step(ins(12, 11, 13, 0, 1, 1), ex("freeze", 1, 0, 0, 1, 1, 1, 1, 1));
        step(ins(12, 11, 13, 0),     ex("resume",      0, 0, 0, 0, 1, 1, 1, 1));
        step(nop(),                  ex("resume_next", 0, 0, 0, 0, 1, 2, 1, 1));

        // Freeze wins over load-use; the stall is then taken.
        step(ins(1, 0, 14, 1),       ex("frz_lu_c1",    0, 0, 0, 0, 0, 0, 1, 1));
        step(ins(14, 0, 15, 0, 0, 1), ex("frz_lu",      1, 0, 0, 1, 0, 0, 1, 1));
        step(ins(14, 0, 15, 0),      ex("lu_after_frz", 1, 1, 0, 0, 0, 0, 1, 1));
        step(ins(14, 0, 15, 0),      ex("lu_release",   0, 0, 0, 0, 0, 0, 2, 1));
        step(ins(1, 0, 16, 0),       ex("lu_fwd",       0, 0, 0, 0, 2, 0, 2, 1));

        // Two older writers of r16: the youngest one is chosen.
        step(ins(1, 0, 16, 0),       ex("pri_c2",       0, 0, 0, 0, 0, 0, 2, 1));
        step(ins(16, 16, 17, 0),     ex("pri_c3",       0, 0, 0, 0, 0, 0, 2, 1));
        step(nop(),                  ex("fwd_priority", 0, 0, 0, 0, 1, 1, 2, 1));

        // 18 more load-use stalls: 16-bit counter reaches 20, 4-bit holds at 15.
        for (int i = 0; i < 18; i++) begin
            step(ins(1, 0, 4, 1),    ex("sat_lw", 0, 0, 0, 0, 0, 0, 2 + i, 1));
            step(ins(4, 0, 18, 0),   ex("sat_lu", 1, 1, 0, 0, 0, 0, 2 + i, 1));
        end
        step(nop(),                  ex("sat_end", 0, 0, 0, 0, 0, 0, 20, 1));

        // Asynchronous reset in the middle of a stall, then during a freeze.
        step(ins(1, 0, 4, 1),        ex("rst_lw", 0, 0, 0, 0, 0, 0, 20, 1));
        @(posedge clk);
        #1 apply(ins(4, 0, 19, 0));
        #1 check("rst_pre_stall", stall_if_id, 1);
        rst_n = 1'b0;
        #1 check_all_zero("rst_mid_stall");
        dmem_stall = 1'b1;
        #1 check_all_zero("rst_mid_freeze");
        @(negedge clk);
        apply(nop());
        #2 rst_n = 1'b1;

        // First post-reset edge loads entry 0 normally.
        step(ins(1, 0, 21, 0),       ex("post_rst_c1",  0, 0, 0, 0, 0, 0, 0, 0));
        step(ins(21, 0, 22, 0),      ex("post_rst_c2",  0, 0, 0, 0, 0, 0, 0, 0));
        step(nop(),                  ex("post_rst_fwd", 0, 0, 0, 0, 1, 0, 0, 0));

        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(posedge clk);
        check("scoreboard_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 Parameters, one per line, as name, default, meaning:
- RA_W, 5, register-address width.
- FWD_DEPTH, 2, post-EX stages tracked (1 = EX/MEM ... FWD_DEPTH = MEM/WB or later), range 1..7.
- LOAD_FWD, 2, first stage index from which load data is forwardable, range 1..FWD_DEPTH.
- CNT_W, 16, performance-counter width.
REQ-002 SEL_W SHALL be clog2(FWD_DEPTH+1).
REQ-003 Ports, one per line, as name, direction, width, meaning:
- clk, in, 1, clock; all state updates on its rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- id_valid, in, 1, ID holds a real instruction.
- id_rs / id_rt, in, RA_W each, ID source registers.
- id_use_rs / id_use_rt, in, 1 each, ID instruction reads rs / rt.
- id_dest, in, RA_W, ID destination (post-RegDst).
- id_regwrite / id_memread, in, 1 each, ID control bits.
- ex_branch_taken, in, 1, branch resolved taken in EX this cycle.
- dmem_stall, in, 1, data memory not ready; freeze pipeline.
- stall_if_id, out, 1, hold PC and IF/ID.
- bubble_id_ex, out, 1, load zeroed controls into ID/EX.
- flush_if_id, out, 1, invalidate IF/ID.
- freeze_all, out, 1, hold every pipeline register.
- fwd_sel_a / fwd_sel_b, out, SEL_W each, EX operand source: 0 = ID/EX register value, k = stage k result.
- stall_cnt / flush_cnt, out, CNT_W each, saturating event counters.

Function
REQ-004 Tracker SHALL hold FWD_DEPTH+1 entries, 0 = EX ... FWD_DEPTH; each entry holds valid, dest, regwrite, is_load, rs, rt.
REQ-005 Entry k "writes r" iff valid && regwrite && dest==r && r!=0.
REQ-006 fwd_sel_a SHALL be the smallest k in 1..FWD_DEPTH whose entry writes entry0.rs, else 0; fwd_sel_b the same on entry0.rt; both 0 when entry0 is invalid.
REQ-007 A load entry k<LOAD_FWD SHALL never be selected; the load-use stall guarantees this never arises.
REQ-008 load_use SHALL be 1 iff id_valid && some entry k<=LOAD_FWD-2 with is_load writes id_rs (id_use_rs) or id_rt (id_use_rt); with LOAD_FWD=1 it is constant 0.
REQ-009 Priority SHALL be dmem_stall > ex_branch_taken > load_use.
REQ-010 When dmem_stall=1: freeze_all=1, stall_if_id=1, bubble_id_ex=0, flush_if_id=0, tracker and counters hold; ex_branch_taken ignored (source holds it).
REQ-011 Else when ex_branch_taken=1: flush_if_id=1, bubble_id_ex=1, stall_if_id=0; flush_cnt increments.
REQ-012 Else when load_use=1: stall_if_id=1, bubble_id_ex=1; stall_cnt increments.
REQ-013 All control outputs SHALL be combinational from current inputs and tracker state (same-cycle response, zero latency).
REQ-014 Each non-frozen edge: entry k moves to k+1, entry FWD_DEPTH is dropped; entry 0 loads the ID fields with valid=id_valid, or valid=0 when bubble_id_ex=1.
REQ-015 Counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-016 rst_n=0 SHALL asynchronously clear every entry valid bit and both counters; outputs then read stall/bubble/flush/freeze=0 and fwd_sel=0.
REQ-017 Reset asserted mid-stall or mid-freeze SHALL override immediately; the first post-reset edge with id_valid=1 loads entry 0 normally.

Verification
REQ-018 Benches SHALL cover, with default parameters, these scenarios:
- add r3 in EX, then sub using r3 -> next cycle fwd_sel_a=1; one cycle later, a use of r3 sees fwd_sel=2.
- lw r4 in EX, ID reads r4 -> stall_if_id=1 and bubble_id_ex=1 for one cycle, stall_cnt=1; next cycle fwd_sel=2, no stall.
- r0 as dest in all stages, ID reads r0 -> no stall; fwd_sel=0.
- load_use and ex_branch_taken together -> flush=1, stall=0, flush_cnt+1, stall_cnt unchanged.
- dmem_stall held 3 cycles mid-forward -> freeze_all=1, fwd_sel constant, tracker unchanged, then resume exactly.
- Counter preset near max via 2^CNT_W stalls (CNT_W=4 build) -> holds at 15; rst_n pulse mid-stall -> all outputs 0 asynchronously.
